// File: rtl/pmc_counter_bank.sv
// rtl/pmc_counter_bank.sv - parametrised performance-monitoring counter bank with shadows, overflow and read-back
module pmc_counter_bank #(
    parameter int NUM_COUNTERS = 4,
    parameter int NUM_EVENTS   = 8,
    parameter int COUNTER_W    = 32,
    localparam int ES_W        = $clog2(NUM_EVENTS),
    localparam int IDX_W       = $clog2(NUM_COUNTERS + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pmc_en,
    input  logic [NUM_EVENTS-1:0]   events,
    input  logic                    clr,
    input  logic                    snap,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic [ES_W-1:0]         cfg_event,
    input  logic                    cfg_en,
    input  logic                    cfg_sat,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [COUNTER_W-1:0]    rd_data,
    output logic                    rd_valid,
    output logic [NUM_COUNTERS:0]   ovf,
    output logic                    irq
);

    // Slot NUM_COUNTERS holds the free-running cycle counter alongside the programmable ones.
    localparam int NSLOT = NUM_COUNTERS + 1;
    localparam int CYC   = NUM_COUNTERS;
    // Event vector padded to the full select range so out-of-range selects read a constant 0.
    localparam int EV_PAD = 1 << ES_W;
    localparam logic [COUNTER_W-1:0] ALL_ONES = '1;

    logic [COUNTER_W-1:0] cnt_q [NSLOT];
    logic [COUNTER_W-1:0] cnt_d [NSLOT];
    logic [COUNTER_W-1:0] shd_q [NSLOT];
    logic [COUNTER_W-1:0] shd_d [NSLOT];
    logic [NSLOT-1:0]     ovf_q, ovf_d;
    logic                 irq_q, irq_d;
    logic [COUNTER_W-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [ES_W-1:0]      sel_q [NUM_COUNTERS];
    logic [ES_W-1:0]      sel_d [NUM_COUNTERS];
    logic [NUM_COUNTERS-1:0] en_q, en_d, sat_q, sat_d;

    logic [EV_PAD-1:0]    ev_pad;
    logic [NSLOT-1:0]     inc;
    logic [NSLOT-1:0]     sat_mode;
    logic [COUNTER_W-1:0] rd_sel;

    // Per-slot increment requests, using the configuration registered before this edge.
    always_comb begin
        ev_pad   = EV_PAD'(events);
        inc      = '0;
        sat_mode = '0;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            inc[k]      = pmc_en & en_q[k] & ev_pad[sel_q[k]];
            sat_mode[k] = sat_q[k];
        end
        inc[CYC] = pmc_en;
    end

    // Live counter and sticky overflow update; clr wins over any same-cycle increment.
    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NSLOT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (clr) begin
                cnt_d[i] = '0;
            end else if (inc[i]) begin
                if (cnt_q[i] == ALL_ONES) begin
                    ovf_d[i] = 1'b1;
                    cnt_d[i] = sat_mode[i] ? ALL_ONES : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + COUNTER_W'(1);
                end
            end
        end
        if (clr) begin
            ovf_d = '0;
        end
    end

    // Shadows capture pre-edge live values; irq follows ovf by one cycle.
    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            shd_d[i] = snap ? cnt_q[i] : shd_q[i];
        end
        irq_d = |ovf_q;
    end

    // Configuration writes; an index with no matching counter updates nothing.
    always_comb begin
        en_d  = en_q;
        sat_d = sat_q;
        for (int k = 0; k < NUM_COUNTERS; k++) begin
            sel_d[k] = sel_q[k];
            if (cfg_we && (cfg_idx == IDX_W'(k))) begin
                sel_d[k] = cfg_event;
                en_d[k]  = cfg_en;
                sat_d[k] = cfg_sat;
            end
        end
    end

    // Registered read port returning the pre-snap shadow; unmapped indices return 0.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < NSLOT; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_sel = shd_q[i];
            end
        end
        rd_valid_d = rd_en;
        rd_data_d  = rd_en ? rd_sel : rd_data_q;
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NSLOT; i++) begin
                cnt_q[i] <= '0;
                shd_q[i] <= '0;
            end
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                sel_q[k] <= '0;
            end
            en_q       <= '0;
            sat_q      <= '0;
            ovf_q      <= '0;
            irq_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < NSLOT; i++) begin
                cnt_q[i] <= cnt_d[i];
                shd_q[i] <= shd_d[i];
            end
            for (int k = 0; k < NUM_COUNTERS; k++) begin
                sel_q[k] <= sel_d[k];
            end
            en_q       <= en_d;
            sat_q      <= sat_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = ovf_q;
    assign irq      = irq_q;

endmodule

// File: doc/pmc_counter_bank.md
Name: pmc_counter_bank

Overview:
- Parametrised performance-monitoring counter bank; successor to the fixed four-counter PMC unit in the SIMD processor top level.
- Each of NUM_COUNTERS programmable counters selects one of NUM_EVENTS single-bit event strobes from the pipeline (stalls, memory accesses, arithmetic ops, branches, jumps, ...).
- Adds a free-running cycle counter, wrap/saturate mode per counter, sticky overflow flags with interrupt, atomic snapshot, and a registered read-back port.

Parameters:
- NUM_COUNTERS, 4, number of programmable counters (1..16).
- NUM_EVENTS, 8, width of the event strobe vector (2..32).
- COUNTER_W, 32, width of every counter, including the cycle counter (8..64).
- ES_W, $clog2(NUM_EVENTS), event-select field width (derived; not overridden).
- IDX_W, $clog2(NUM_COUNTERS+1), counter index width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pmc_en  in  1  global count enable; 0 freezes all counting.
- events  in  NUM_EVENTS  one-cycle event strobes; bit i = event i occurred this cycle.
- clr  in  1  pulse: zero all live counters and overflow flags.
- snap  in  1  pulse: copy all live counters into shadow registers.
- cfg_we  in  1  configuration write strobe.
- cfg_idx  in  IDX_W  counter to configure (0..NUM_COUNTERS-1).
- cfg_event  in  ES_W  event select.
- cfg_en  in  1  per-counter enable.
- cfg_sat  in  1  1 = saturate, 0 = wrap.
- rd_en  in  1  read request.
- rd_idx  in  IDX_W  0..NUM_COUNTERS-1 = programmable shadows; NUM_COUNTERS = cycle-counter shadow.
- rd_data  out  COUNTER_W  read result.
- rd_valid  out  1  high for one cycle when rd_data is valid.
- ovf  out  NUM_COUNTERS+1  sticky overflow flags; MSB = cycle counter.
- irq  out  1  registered OR of ovf.

Behaviour:
- Reset (async): all live counters, shadows, ovf, irq, rd_data and rd_valid = 0; every configuration = {event 0, en 0, sat 0}.
- Cycle counter: increments by 1 on each clk edge while pmc_en = 1; always wraps.
- Counter k: increments on an edge when pmc_en & cfg_en[k] & events[cfg_event[k]].
- An event select >= NUM_EVENTS never counts.
- Overflow: an increment from all-ones sets ovf[k].
  - Wrap mode: count goes to 0.
  - Saturate mode: count holds at all-ones.
  - In saturate mode, ovf[k] is set once on the first overflow; further increments leave the count at all-ones.
- ovf bits are sticky until clr or reset.
- irq is registered from ovf: it rises one cycle after the ovf bit sets.
- Configuration write:
  - Takes effect on the edge after cfg_we. An increment in the write cycle uses the old configuration.
  - cfg_idx >= NUM_COUNTERS is ignored.
  - A configuration write does not alter the count value.
- clr:
  - On the edge, all live counters (including the cycle counter) = 0 and ovf = 0. Any increment in the same cycle is discarded.
  - Shadows are not cleared.
- snap:
  - Shadows capture the live values present before the edge, i.e. excluding this cycle's increment.
  - snap & clr in the same cycle = atomic read-and-clear: shadows get the old values, live counters go to 0.
- Read:
  - rd_en at cycle t gives rd_valid = 1 and rd_data = shadow[rd_idx] at t+1.
  - rd_idx > NUM_COUNTERS returns 0 with rd_valid = 1.
  - rd_data holds its value while rd_en = 0; rd_valid = 0 otherwise.
  - A snap in the same cycle as rd_en: the read returns the pre-snap shadow value.
- pmc_en = 0 freezes counting only. clr, snap, configuration and read operate regardless.
- A reset asserted mid-operation immediately returns all state to the reset values; there is no partial update.

Test Plan:
- Basic count (COUNTER_W=8): configure counter 0 = {event 2, en 1}, pulse events[2] 5 times, snap, read idx 0 -> rd_data = 5 one cycle after rd_en; cycle-counter read (idx NUM_COUNTERS) equals the elapsed enabled cycles.
- Wrap vs saturate (COUNTER_W=8): counter 1 wrap, counter 2 saturate, same event held high for 257 cycles -> counter 1 = 1, counter 2 = 255; ovf[1] = ovf[2] = 1; irq = 1 one cycle after the first ovf bit.
- Read-and-clear: live counter 0 = 10, snap and clr in the same cycle with the event also high -> shadow = 10, live = 0, ovf = 0; the next event gives live = 1.
- Freeze and config timing: pmc_en = 0 for 20 event cycles -> no counter changes. With pmc_en = 1, retarget counter 0 from event 2 to event 3 while both events are high -> the write cycle counts once via the old select, then counting follows event 3 only.
- Boundary indices: cfg_idx = NUM_COUNTERS write -> no configuration change; rd_idx = NUM_COUNTERS+1 -> rd_data = 0, rd_valid = 1; cfg_event >= NUM_EVENTS (NUM_EVENTS=6) -> counter never increments.
- Async reset mid-count: assert reset between clock edges with counters nonzero and irq = 1 -> all outputs 0 immediately, before the next clk edge; configurations back to disabled.
